// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with inline ALU decode, illegal-opcode trap and retired-instruction counter.
// Optional macro MC_BRANCH_EXT_EN enables the full RV32I conditional-branch set.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W      = 3,
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT} alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state, next_state;
  alu_op_t    alu_op;
  logic [2:0] alu_ctrl3, alu_funct;
  logic       pc_update, branch, taken, branch_legal, decode_bad, nop_done;
  logic       mem_write_c, ir_write_c, reg_write_c;

  // Branch condition and legality: only beq in the base build.
`ifdef MC_BRANCH_EXT_EN
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end
  assign branch_legal = (funct3[2:1] != 2'b01);
`else
  logic unused_flags;
  assign unused_flags = lt ^ ltu;
  assign taken        = (funct3 == 3'b000) && zero;
  assign branch_legal = (funct3 == 3'b000);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal     <= 1'b0;
      nop_done    <= 1'b0;
      instr_count <= '0;
    end else begin
      if (decode_bad) illegal <= 1'b1;
      nop_done <= decode_bad && (HALT_ON_ILLEGAL == 0);
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state  = state;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_op      = ALU_OP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    instr_done  = 1'b0;
    decode_bad  = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        instr_done = nop_done;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH: begin
            next_state = S_BRANCH;
            decode_bad = !branch_legal;
          end
          OP_JAL:            next_state = S_JAL;
          default:           decode_bad = 1'b1;
        endcase
        if (decode_bad) next_state = (HALT_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = op[5] ? 2'b01 : 2'b00;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_OP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // funct7_5 selects sub only for register-register ops (op[5] set).
  always_comb begin
    alu_funct = 3'b000;
    case (funct3)
      3'b000:  alu_funct = ({op[5], funct7_5} == 2'b11) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    alu_ctrl3 = 3'b000;
    case (alu_op)
      ALU_OP_SUB:   alu_ctrl3 = 3'b001;
      ALU_OP_FUNCT: alu_ctrl3 = alu_funct;
      default:      alu_ctrl3 = 3'b000;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(alu_ctrl3);

  // Reset masks write enables combinationally since FETCH itself asserts ir_write and pc_update.
  assign pc_write  = !reset && (pc_update || (branch && taken));
  assign mem_write = !reset && mem_write_c;
  assign ir_write  = !reset && ir_write_c;
  assign reg_write = !reset && reg_write_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit: a halting instance (h_) and a NOP-on-illegal instance (n_).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu;

  logic        h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_instr_done, h_illegal;
  logic [1:0]  h_result_src, h_alu_src_a, h_alu_src_b, h_imm_src;
  logic [2:0]  h_alu_control;
  logic [31:0] h_instr_count;
  logic        n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_instr_done, n_illegal;
  logic [1:0]  n_result_src, n_alu_src_a, n_alu_src_b, n_imm_src;
  logic [2:0]  n_alu_control;
  logic [31:0] n_instr_count;

  logic [3:0] h_en, n_en;
  assign h_en = {h_pc_write, h_mem_write, h_ir_write, h_reg_write};
  assign n_en = {n_pc_write, n_mem_write, n_ir_write, n_reg_write};

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_CTRL_W(3), .CNT_W(32), .HALT_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu),
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write), .ir_write(h_ir_write),
    .reg_write(h_reg_write), .result_src(h_result_src), .alu_src_a(h_alu_src_a),
    .alu_src_b(h_alu_src_b), .imm_src(h_imm_src), .alu_control(h_alu_control),
    .instr_done(h_instr_done), .illegal(h_illegal), .instr_count(h_instr_count)
  );

  multicycle_control_unit #(.ALU_CTRL_W(3), .CNT_W(32), .HALT_ON_ILLEGAL(0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu),
    .pc_write(n_pc_write), .adr_src(n_adr_src), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_write(n_reg_write), .result_src(n_result_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .imm_src(n_imm_src), .alu_control(n_alu_control),
    .instr_done(n_instr_done), .illegal(n_illegal), .instr_count(n_instr_count)
  );

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zero, lt, ltu;
    int         cycles;
    logic [2:0] c3_alu;
    logic       c3_pc;
    logic       l_pc, l_reg, l_mem;
    logic [1:0] l_rs;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_h    = 0;
  int   exp_n    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Entered at a negedge with the machine in FETCH; leaves at the negedge of the next FETCH.
  task automatic run_instr(input vec_t v);
    int done_cyc = 0;
    op = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.zero; lt = v.lt; ltu = v.ltu;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      #1;
      if (cyc == 1) begin
        check({v.name, "_fetch_en"}, h_en, 4'b1010);
        check({v.name, "_fetch_mux"}, {h_adr_src, h_result_src, h_alu_src_b}, {1'b0, 2'b10, 2'b10});
      end
      if (cyc == 3) begin
        check({v.name, "_c3_alu"}, h_alu_control, v.c3_alu);
        check({v.name, "_c3_pcw"}, h_pc_write, v.c3_pc);
      end
      if (h_instr_done) done_cyc = cyc;
      @(negedge clk);
      if (done_cyc != 0) break;
    end
    check({v.name, "_cycles"}, done_cyc, v.cycles);
    exp_h++; exp_n++;
    #1;
    check({v.name, "_count"}, h_instr_count, exp_h);
    check({v.name, "_count_nop"}, n_instr_count, exp_n);
  endtask

  // Last-cycle enables are sampled by a second pass that walks to the final cycle only.
  task automatic run_last(input vec_t v);
    op = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.zero; lt = v.lt; ltu = v.ltu;
    for (int cyc = 1; cyc < v.cycles; cyc++) @(negedge clk);
    #1;
    check({v.name, "_last_done"}, h_instr_done, 1'b1);
    check({v.name, "_last_en"}, {h_pc_write, h_reg_write, h_mem_write}, {v.l_pc, v.l_reg, v.l_mem});
    check({v.name, "_last_rs"}, h_result_src, v.l_rs);
    @(negedge clk);
    exp_h++; exp_n++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[1]  = '{"sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2]  = '{"add",    7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[3]  = '{"sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[4]  = '{"slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[5]  = '{"or",     7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{"and",    7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[7]  = '{"xor",    7'b0110011, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[8]  = '{"addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[9]  = '{"slti",   7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[10] = '{"jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[11] = '{"beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[12] = '{"beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    #1;
    check("rst_en", h_en, 4'b0000);
    check("rst_illegal", {h_illegal, n_illegal}, 2'b00);
    check("rst_count", h_instr_count, 32'd0);

    // Start a load, then abort it with reset while in MEMREAD.
    @(negedge clk);
    reset = 1'b0;
    #1 check("lw0_fetch_ir", h_ir_write, 1'b1);
    @(negedge clk);
    #1 check("lw0_decode_mux", {h_alu_src_a, h_alu_src_b, h_imm_src}, {2'b01, 2'b01, 2'b10});
    @(negedge clk);
    #1 check("lw0_memadr_mux", {h_alu_src_a, h_alu_src_b, h_imm_src}, {2'b10, 2'b01, 2'b00});
    @(negedge clk);
    #1 check("lw0_memread", {h_adr_src, h_result_src, h_en}, {1'b1, 2'b00, 4'b0000});
    reset = 1'b1;
    #1;
    check("midrst_en", h_en, 4'b0000);
    check("midrst_fetch_vals", {h_adr_src, h_result_src, h_alu_src_b}, {1'b0, 2'b10, 2'b10});
    @(negedge clk);
    #1;
    check("midrst_hold_en", h_en, 4'b0000);
    check("midrst_count", h_instr_count, 32'd0);
    reset = 1'b0;
    #1 check("post_rst_ir", h_ir_write, 1'b1);

    for (int i = 0; i < 13; i++) run_instr(vecs[i]);
    foreach (vecs[i]) if (vecs[i].cycles != 5 || i == 0) run_last(vecs[i]);
    #1 check("table_count", h_instr_count, exp_h);

    // bne with zero = 0: illegal in the base build, taken in the extended build.
    op = 7'b1100011; funct3 = 3'b001; funct7_5 = 1'b0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
`ifdef MC_BRANCH_EXT_EN
    check("bne_taken", {h_pc_write, n_pc_write, h_instr_done}, 3'b111);
    exp_h++; exp_n++;
    @(negedge clk);
    #1;
`else
    check("bne_trap_en", h_en, 4'b0000);
    check("bne_trap_flags", {h_illegal, h_instr_done}, 2'b10);
    check("bne_nop", {n_instr_done, n_illegal, n_ir_write}, 3'b111);
    exp_n++;
`endif
    op = 7'b1111111; funct3 = 3'b000;
    @(negedge clk);
    #1;
    check("ill_decode_count", n_instr_count, exp_n);
    check("ill_decode_count_h", h_instr_count, exp_h);
    @(negedge clk);
    #1;
    check("ill_nop_fetch", {n_instr_done, n_illegal, n_ir_write}, 3'b111);
    check("ill_trap", {h_en, h_illegal, h_instr_done}, {4'b0000, 1'b1, 1'b0});
    exp_n++;
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    @(negedge clk);
    #1 check("after_nop_count", n_instr_count, exp_n);
    @(negedge clk);
    #1 check("after_nop_execr", {n_alu_control, n_alu_src_a, n_alu_src_b}, {3'b000, 2'b10, 2'b00});
    @(negedge clk);
    #1 check("after_nop_aluwb", {n_reg_write, n_instr_done}, 2'b11);
    exp_n++;
    @(negedge clk);
    #1;
    check("after_nop_count2", n_instr_count, exp_n);
    check("trap_sticky", {h_en, h_illegal, h_instr_done}, {4'b0000, 1'b1, 1'b0});
    check("trap_count_frozen", h_instr_count, exp_h);

    reset = 1'b1;
    #1;
    check("final_rst_illegal", {h_illegal, n_illegal}, 2'b00);
    check("final_rst_count", {h_instr_count, n_instr_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("trap_exit_fetch", h_en, 4'b1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based control unit for the multi-cycle RV32I datapath: shared instruction/data memory, IR/OldPC/ALUOut/Data registers, one ALU.
- Sequences each instruction over 3-5 cycles. Drives the datapath mux selects and write enables from the current state.
- Decodes ALU control inline from alu_op/funct3/funct7_5/op[5].
- Adds illegal-opcode detection and a retired-instruction counter.

Parameters:
- ALU_CTRL_W, 3: alu_control width. Upper bits beyond 3 are zero-filled.
- CNT_W, 32: retired-instruction counter width.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters sticky TRAP; 0 = illegal opcode is treated as a NOP and returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; state to FETCH, counters cleared
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- lt  in  1  ALU signed less-than flag (used only with MC_BRANCH_EXT_EN)
- ltu  in  1  ALU unsigned less-than flag (used only with MC_BRANCH_EXT_EN)
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  memory write enable
- ir_write  out  1  IR/OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rd1
- alu_src_b  out  2  00 = rd2, 01 = imm, 10 = const 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky illegal-instruction flag
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Outputs are Moore outputs from the registered state, except pc_write = pc_update | (branch & taken).
- While reset is asserted: state = FETCH; illegal = 0; instr_count = 0; pc_write, mem_write, ir_write, reg_write all forced to 0. Other outputs take their FETCH values.
- After reset deasserts, the first rising edge executes FETCH.
- A reset mid-instruction aborts it immediately: no write enable is asserted afterwards, and the instruction is not counted.
- FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, alu_op add, result_src 10, pc_update 1. Next state: DECODE.
- DECODE: alu_src_a 01, alu_src_b 01, imm_src 10, alu_op add (branch target). Next state by op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other op -> TRAP if HALT_ON_ILLEGAL, else FETCH
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op add. imm_src is 00 for loads, 01 for stores. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: result_src 00, adr_src 1. Next: MEMWB.
- MEMWB: result_src 01, reg_write 1. Next: FETCH.
- MEMWRITE: result_src 00, adr_src 1, mem_write 1. Next: FETCH.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op funct. Next: ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, imm_src 00, alu_op funct. Next: ALUWB.
- ALUWB: result_src 00, reg_write 1. Next: FETCH.
- BRANCH: alu_src_a 10, alu_src_b 00, alu_op sub, result_src 00, branch 1. Next: FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op add, result_src 00, pc_update 1. Next: ALUWB.
- Latency per instruction:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - branch: 3 cycles
- ALU decode (alu_op funct):
  - funct3 000: sub if {op[5], funct7_5} = 11, otherwise add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - any other funct3: add
- Branch taken (base build): funct3 000 and zero.
- A branch with any other funct3 is illegal and is handled like an illegal opcode at DECODE.
- instr_done: high during MEMWB, MEMWRITE, ALUWB, BRANCH, and FETCH-after-DECODE NOP.
- instr_count increments by 1 on each clock edge where instr_done = 1. It wraps modulo 2^CNT_W.
- TRAP: all enables 0. illegal = 1 and holds until reset. Stays in TRAP.
- illegal is set on entry to TRAP. When HALT_ON_ILLEGAL = 0, illegal is set for the NOP case as well, and the machine continues.

Optional Feature:
- Macro MC_BRANCH_EXT_EN.
- When defined, BRANCH decodes the full RV32I set:
  - 000 beq: zero
  - 001 bne: !zero
  - 100 blt: lt
  - 101 bge: !lt
  - 110 bltu: ltu
  - 111 bgeu: !ltu
  - 010 and 011 remain illegal.
- When undefined: lt and ltu are ignored, and only beq is legal.

Test Plan:
- Reset asserted mid-MEMREAD, then released -> state FETCH, all enables 0 during reset, instr_count 0, ir_write 1 on first cycle.
- lw (op 0000011) -> exactly 5 cycles: ir_write in cycle 1, reg_write with result_src 01 in cycle 5, instr_count +1.
- add then sub (op 0110011, funct3 000, funct7_5 0 then 1) -> alu_control 000 then 001 in EXECR; 4 cycles each; instr_count = 2.
- beq with zero 1 -> pc_write 1 in cycle 3. beq with zero 0 -> pc_write 0. Both take 3 cycles.
- bne (funct3 001) with zero 0 -> with macro: pc_write 1. Without macro and HALT_ON_ILLEGAL = 1: TRAP, illegal = 1 sticky, no further enables.
- op 1111111 with HALT_ON_ILLEGAL = 0 -> FETCH after DECODE, illegal = 1, instr_count +1, next instruction executes normally.
